// File: rtl/secuenciador_rtc_if.sv
// Engine-side bus of the RTC sequencer: start/write/address/data out, done/RD/read-data back.
// The controller uses the master modport, the bus engine (or its model) the slave modport.
interface secuenciador_rtc_if;
  logic       iniciar;
  logic       escribe;
  logic [7:0] direccion;
  logic [7:0] dato;
  logic       fin;
  logic       rd_bus;
  logic [7:0] dato_rtc;

  modport master (
    output iniciar, escribe, direccion, dato,
    input  fin, rd_bus, dato_rtc
  );

  modport slave (
    input  iniciar, escribe, direccion, dato,
    output fin, rd_bus, dato_rtc
  );
endinterface

// File: rtl/secuenciador_rtc.sv
// RTC bus scheduler: periodic 6-register time sweep plus user writes, coherent snapshot
// publication and engine-hang recovery through a per-transaction timeout.
module secuenciador_rtc #(
  parameter int         PERIODO   = 1_000_000,
  parameter logic [7:0] ADDR_BASE = 8'h21,
  parameter int         TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               habilita,
  input  logic               wr_req,
  input  logic [7:0]         wr_dir,
  input  logic [7:0]         wr_dato,
  output logic               wr_ack,
  secuenciador_rtc_if.master bus,
  output logic [7:0]         segundos,
  output logic [7:0]         minutos,
  output logic [7:0]         horas,
  output logic [7:0]         dia,
  output logic [7:0]         mes,
  output logic [7:0]         anio,
  output logic               nuevo_dato,
  output logic               error
);
  localparam int         TW     = $clog2(PERIODO);
  localparam int         OW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0] ULTIMO = 3'd5;

  typedef enum logic [1:0] {REPOSO, ACTIVA, LIBERA} estado_t;

  estado_t         estado_reg;
  logic [TW-1:0]   tick_reg;
  logic            pend_reg;
  logic            barrido_reg;
  logic            ack_diferido_reg;
  logic            rd_q_reg;
  logic [2:0]      indice_reg;
  logic [OW-1:0]   to_reg;
  logic [5:0][7:0] shadow_reg;
  logic [5:0][7:0] shadow_val;

  logic tick_wrap;
  logic captura;
  logic acepta_wr;

  assign tick_wrap = habilita && (tick_reg == TW'(PERIODO - 1));
  assign captura   = (estado_reg == ACTIVA) && !bus.escribe && barrido_reg &&
                     bus.rd_bus && !rd_q_reg;
  // A request still high while its own ack is visible (or while releasing the
  // write that just ended) belongs to that write and must not start another.
  assign acepta_wr = wr_req && !wr_ack && !((estado_reg == LIBERA) && bus.escribe);

  // Bypassed shadow view so a capture on the closing edge is part of the commit.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_shadow
      assign shadow_val[gi] = (captura && (indice_reg == 3'(gi))) ? bus.dato_rtc
                                                                  : shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shadow_reg <= '0;
    else        shadow_reg <= shadow_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_reg       <= REPOSO;
      tick_reg         <= '0;
      pend_reg         <= 1'b0;
      barrido_reg      <= 1'b0;
      ack_diferido_reg <= 1'b0;
      rd_q_reg         <= 1'b1;
      indice_reg       <= '0;
      to_reg           <= '0;
      bus.iniciar      <= 1'b0;
      bus.escribe      <= 1'b0;
      bus.direccion    <= '0;
      bus.dato         <= '0;
      wr_ack           <= 1'b0;
      nuevo_dato       <= 1'b0;
      error            <= 1'b0;
      segundos         <= '0;
      minutos          <= '0;
      horas            <= '0;
      dia              <= '0;
      mes              <= '0;
      anio             <= '0;
    end else begin
      wr_ack           <= ack_diferido_reg;
      ack_diferido_reg <= 1'b0;
      error            <= 1'b0;
      nuevo_dato       <= 1'b0;
      rd_q_reg         <= bus.rd_bus;

      if (!habilita || tick_wrap) tick_reg <= '0;
      else                        tick_reg <= tick_reg + TW'(1);

      case (estado_reg)
        REPOSO, LIBERA: begin
          to_reg <= '0;
          if (acepta_wr) begin
            bus.direccion <= wr_dir;
            bus.dato      <= wr_dato;
            bus.escribe   <= 1'b1;
            bus.iniciar   <= 1'b1;
            estado_reg    <= ACTIVA;
          end else if ((estado_reg == LIBERA) && barrido_reg) begin
            indice_reg    <= indice_reg + 3'd1;
            bus.direccion <= ADDR_BASE + 8'(indice_reg) + 8'd1;
            bus.escribe   <= 1'b0;
            bus.iniciar   <= 1'b1;
            estado_reg    <= ACTIVA;
          end else if ((estado_reg == REPOSO) && pend_reg) begin
            pend_reg      <= 1'b0;
            barrido_reg   <= 1'b1;
            indice_reg    <= '0;
            bus.direccion <= ADDR_BASE;
            bus.escribe   <= 1'b0;
            bus.iniciar   <= 1'b1;
            estado_reg    <= ACTIVA;
          end else begin
            estado_reg <= REPOSO;
          end
        end

        ACTIVA: begin
          if (bus.fin) begin
            bus.iniciar <= 1'b0;
            estado_reg  <= LIBERA;
            if (bus.escribe) begin
              wr_ack <= 1'b1;
            end else if (barrido_reg && (indice_reg == ULTIMO)) begin
              {anio, mes, dia, horas, minutos, segundos} <= shadow_val;
              nuevo_dato  <= 1'b1;
              barrido_reg <= 1'b0;
            end
          end else if (to_reg == OW'(TIMEOUT - 1)) begin
            bus.iniciar <= 1'b0;
            estado_reg  <= LIBERA;
            error       <= 1'b1;
            // A hung write is still acknowledged, one cycle after its error pulse.
            if (bus.escribe) ack_diferido_reg <= 1'b1;
            else             barrido_reg      <= 1'b0;
          end else begin
            to_reg <= to_reg + OW'(1);
          end
        end

        default: begin
          bus.iniciar <= 1'b0;
          estado_reg  <= REPOSO;
        end
      endcase

      // Placed after the FSM so a wrap on the consuming cycle is not lost.
      if (tick_wrap) pend_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_secuenciador_rtc.sv
// Self-checking bench for secuenciador_rtc: engine model, transaction scoreboard,
// vector tables for writes and sweeps, and hand-written timeout/reset sequences.
module tb_secuenciador_rtc;
  localparam int PERIODO = 100;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic       escribe;
    logic [7:0] dir;
    logic [7:0] dato;
  } tx_t;

  typedef struct {
    logic [7:0] dir;
    logic [7:0] dat;
    logic [7:0] exp_dir;
    logic [7:0] exp_dato;
  } wr_vec_t;

  typedef struct {
    logic [7:0]  base;
    logic [47:0] exp_snap;
  } sw_vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       habilita = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_dir = 8'h00;
  logic [7:0] wr_dato = 8'h00;
  logic       wr_ack;
  logic [7:0] segundos, minutos, horas, dia, mes, anio;
  logic       nuevo_dato;
  logic       error;

  secuenciador_rtc_if bus();

  always #5 clk = ~clk;

  secuenciador_rtc #(
    .PERIODO  (PERIODO),
    .ADDR_BASE(8'h21),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .habilita  (habilita),
    .wr_req    (wr_req),
    .wr_dir    (wr_dir),
    .wr_dato   (wr_dato),
    .wr_ack    (wr_ack),
    .bus       (bus),
    .segundos  (segundos),
    .minutos   (minutos),
    .horas     (horas),
    .dia       (dia),
    .mes       (mes),
    .anio      (anio),
    .nuevo_dato(nuevo_dato),
    .error     (error)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  tx_t  exp_q[$];
  int   tx_started = 0;
  int   nd_cnt = 0;
  int   ack_cnt = 0;
  int   err_cnt = 0;
  int   hi_len = 0;
  int   last_hi_len = 0;
  logic [7:0] bfm_base = 8'h00;
  logic bfm_hang = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endfunction

  function automatic logic [47:0] snap();
    return {anio, mes, dia, horas, minutos, segundos};
  endfunction

  function automatic int get_cnt(input int which);
    case (which)
      0:       return nd_cnt;
      1:       return err_cnt;
      default: return tx_started;
    endcase
  endfunction

  // Waits (bounded) until the selected event counter moves past 'start'.
  task automatic wait_cnt(input int which, input int start, input int budget, input string name);
    int k;
    for (k = 0; k < budget && get_cnt(which) == start; k++) @(negedge clk);
    n_chk++;
    if (get_cnt(which) == start) begin
      n_fail++;
      $display("FAIL %s: no event within %0d cycles, required one", name, budget);
    end
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 6; i++) exp_q.push_back('{1'b0, 8'h21 + 8'(i), 8'h00});
  endtask

  task automatic do_write(input logic [7:0] d, input logic [7:0] v, input string name);
    int k;
    wr_dir  = d;
    wr_dato = v;
    wr_req  = 1'b1;
    for (k = 0; k < 200 && !wr_ack; k++) @(negedge clk);
    wr_req = 1'b0;
    n_chk++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL %s: wr_ack never seen, required within 200 cycles", name);
    end
  endtask

  // Engine model: read pulses RD low then high with data, done after 6 cycles.
  initial begin
    int cnt;
    cnt = 0;
    bus.fin = 1'b0;
    bus.rd_bus = 1'b1;
    bus.dato_rtc = 8'h00;
    forever begin
      @(negedge clk);
      if (!bus.iniciar) begin
        cnt = 0;
        bus.fin = 1'b0;
        bus.rd_bus = 1'b1;
      end else begin
        cnt++;
        if (!bus.escribe) begin
          if (cnt == 2) bus.rd_bus = 1'b0;
          if (cnt == 3) bus.dato_rtc = bfm_base + (bus.direccion - 8'h21);
          if (cnt == 4) bus.rd_bus = 1'b1;
        end
        if (cnt == 6 && !bfm_hang) bus.fin = 1'b1;
      end
    end
  end

  // Monitor / scoreboard, sampled 1 time unit after each rising edge.
  initial begin
    logic ini_q;
    tx_t  e;
    ini_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.iniciar && !ini_q) begin
        tx_started++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_unexpected: got escribe=%0b dir=%h, required no transaction",
                   bus.escribe, bus.direccion);
        end else begin
          e = exp_q.pop_front();
          chk("tx_escribe", 64'(bus.escribe), 64'(e.escribe));
          chk("tx_dir", 64'(bus.direccion), 64'(e.dir));
          if (e.escribe) chk("tx_dato", 64'(bus.dato), 64'(e.dato));
        end
      end
      if (bus.fin) chk("iniciar_drop_after_final", 64'(bus.iniciar), 64'd0);
      if (bus.iniciar) hi_len++;
      else if (ini_q) begin
        last_hi_len = hi_len;
        hi_len = 0;
      end
      if (nuevo_dato) nd_cnt++;
      if (wr_ack) ack_cnt++;
      if (error) err_cnt++;
      ini_q = bus.iniciar;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    wr_vec_t wr_tab[3];
    sw_vec_t sw_tab[2];
    int a0, n0, e0, t0;

    wr_tab[0] = '{8'h10, 8'hA5, 8'h10, 8'hA5};
    wr_tab[1] = '{8'h0F, 8'h00, 8'h0F, 8'h00};
    wr_tab[2] = '{8'hFF, 8'h5A, 8'hFF, 8'h5A};
    sw_tab[0] = '{8'h30, 48'h35_34_33_32_31_30};
    sw_tab[1] = '{8'h59, 48'h5E_5D_5C_5B_5A_59};

    repeat (3) @(negedge clk);
    chk("reset_snapshot", 64'(snap()), 64'd0);
    chk("reset_ctrl", 64'({bus.iniciar, bus.escribe, bus.direccion, bus.dato,
                           wr_ack, nuevo_dato, error}), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Writes with sweeps disabled: exactly one write transaction and one ack each.
    for (int i = 0; i < 3; i++) begin
      a0 = ack_cnt;
      exp_q.push_back('{1'b1, wr_tab[i].exp_dir, wr_tab[i].exp_dato});
      do_write(wr_tab[i].dir, wr_tab[i].dat, "write_ack");
      repeat (20) @(negedge clk);
      chk("write_single_ack", 64'(ack_cnt - a0), 64'd1);
    end
    chk("no_reads_while_disabled", 64'(exp_q.size()), 64'd0);

    // Periodic sweeps.
    for (int i = 0; i < 2; i++) begin
      n0 = nd_cnt;
      bfm_base = sw_tab[i].base;
      push_sweep();
      habilita = 1'b1;
      wait_cnt(0, n0, 300, "sweep_nuevo_dato");
      habilita = 1'b0;
      repeat (20) @(negedge clk);
      chk("sweep_snapshot", 64'(snap()), 64'(sw_tab[i].exp_snap));
      chk("sweep_single_nuevo", 64'(nd_cnt - n0), 64'd1);
      chk("sweep_all_reads", 64'(exp_q.size()), 64'd0);
    end

    // Write raised during read index 2 runs between reads 2 and 3.
    n0 = nd_cnt;
    a0 = ack_cnt;
    t0 = tx_started;
    bfm_base = 8'h40;
    for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 8'h21 + 8'(i), 8'h00});
    exp_q.push_back('{1'b1, 8'h33, 8'h77});
    for (int i = 3; i < 6; i++) exp_q.push_back('{1'b0, 8'h21 + 8'(i), 8'h00});
    habilita = 1'b1;
    wait_cnt(2, t0, 300, "sweep_start");
    wait_cnt(2, t0 + 1, 50, "read1_start");
    wait_cnt(2, t0 + 2, 50, "read2_start");
    do_write(8'h33, 8'h77, "preempt_write_ack");
    wait_cnt(0, n0, 200, "preempt_nuevo_dato");
    habilita = 1'b0;
    repeat (20) @(negedge clk);
    chk("preempt_snapshot", 64'(snap()), 64'h45_44_43_42_41_40);
    chk("preempt_single_nuevo", 64'(nd_cnt - n0), 64'd1);
    chk("preempt_single_ack", 64'(ack_cnt - a0), 64'd1);

    // Hung engine: timeout, no commit, then the next sweep recovers.
    n0 = nd_cnt;
    e0 = err_cnt;
    bfm_hang = 1'b1;
    exp_q.push_back('{1'b0, 8'h21, 8'h00});
    habilita = 1'b1;
    wait_cnt(1, e0, 300, "timeout_error");
    bfm_hang = 1'b0;
    bfm_base = 8'h50;
    push_sweep();
    repeat (3) @(negedge clk);
    chk("timeout_iniciar_len", 64'(last_hi_len), 64'(TIMEOUT));
    chk("timeout_iniciar_low", 64'(bus.iniciar), 64'd0);
    chk("timeout_single_error", 64'(err_cnt - e0), 64'd1);
    chk("timeout_no_nuevo", 64'(nd_cnt - n0), 64'd0);
    chk("timeout_snapshot_held", 64'(snap()), 64'h45_44_43_42_41_40);
    wait_cnt(0, n0, 300, "recovery_nuevo_dato");
    habilita = 1'b0;
    repeat (20) @(negedge clk);
    chk("recovery_snapshot", 64'(snap()), 64'h55_54_53_52_51_50);

    // Reset in the middle of a read.
    t0 = tx_started;
    bfm_base = 8'h60;
    exp_q.push_back('{1'b0, 8'h21, 8'h00});
    habilita = 1'b1;
    wait_cnt(2, t0, 300, "pre_reset_read_start");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_iniciar", 64'(bus.iniciar), 64'd0);
    chk("async_reset_outputs", 64'(snap()), 64'd0);
    @(negedge clk);
    n0 = nd_cnt;
    bfm_base = 8'h61;
    push_sweep();
    reset = 1'b1;
    wait_cnt(0, n0, 300, "post_reset_nuevo_dato");
    habilita = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_reset_snapshot", 64'(snap()), 64'h66_65_64_63_62_61);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
